// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch (tag FIFO + instruction buffer); FETCH_ADEF_EN adds misaligned-PC exception entries.
// Latency: data_ok -> decode-visible 1 cycle; backpressure: requests stop once outstanding + buffered would fill the buffer.
module fetch_unit #(
   parameter logic [31:0] RESET_PC        = 32'h1c000000,
   parameter int          IBUF_DEPTH      = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   input  logic        flush_valid,
   input  logic [31:0] flush_target,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   input  logic        ds_allowin,
   output logic        fs_to_ds_valid,
   output logic [31:0] fs_to_ds_pc,
   output logic [31:0] fs_to_ds_inst,
   output logic        fs_to_ds_excp
);

   localparam int            AW        = $clog2(IBUF_DEPTH);
   localparam int            CW        = AW + 1;
   localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUTSTANDING);
   localparam logic [CW:0]   DEPTH_C   = (CW+1)'(IBUF_DEPTH);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ibuf_entry_t;

   logic [31:0]   pc;
   logic [CW-1:0] out_cnt, out_nxt;
   logic [CW-1:0] discard_cnt;
   logic [CW-1:0] ibuf_cnt, ib_cnt_nxt;

   // Tag FIFO shares the buffer's depth, which bounds MAX_OUTSTANDING.
   logic [31:0]   tag_mem [IBUF_DEPTH];
   logic [AW-1:0] tag_wr, tag_rd;
   ibuf_entry_t   ibuf_mem [IBUF_DEPTH];
   logic [AW-1:0] ib_wr, ib_rd;

   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          room, accept, resp, ib_push, ib_pop;
   logic          pc_misal, adef_push;
   ibuf_entry_t   ib_wdata;

`ifdef FETCH_ADEF_EN
   logic                  adef_done;
   logic [IBUF_DEPTH-1:0] ib_excp;
`endif

   always_comb begin
      redirect    = flush_valid | br_valid;
      redirect_pc = flush_valid ? flush_target : br_target;
`ifdef FETCH_ADEF_EN
      pc_misal      = (pc[1:0] != 2'b00);
      adef_push     = pc_misal && !adef_done && (out_cnt == '0) &&
                      ({1'b0, ibuf_cnt} < DEPTH_C) && !redirect && !reset;
      inst_addr     = pc;
      fs_to_ds_excp = ib_excp[ib_rd];
`else
      pc_misal      = 1'b0;
      adef_push     = 1'b0;
      inst_addr     = {pc[31:2], 2'b00};
      fs_to_ds_excp = 1'b0;
`endif
      // Every accepted request keeps a buffer slot reserved until its response lands.
      room     = ({1'b0, out_cnt} + {1'b0, ibuf_cnt}) < DEPTH_C;
      inst_req = !reset && (out_cnt < MAX_OUT_C) && room && !redirect && !pc_misal;
      accept   = inst_req & inst_addr_ok;
      // A response with nothing outstanding is a leftover from before reset.
      resp     = inst_data_ok && (out_cnt != '0) && !reset;
      ib_push  = ((resp && (discard_cnt == '0)) || adef_push) && !redirect;

      fs_to_ds_valid = !reset && (ibuf_cnt != '0) && !redirect;
      ib_pop         = fs_to_ds_valid & ds_allowin;

      ib_wdata.pc   = adef_push ? pc : tag_mem[tag_rd];
      ib_wdata.inst = adef_push ? 32'h0 : inst_rdata;

      out_nxt = out_cnt;
      case ({accept, resp})
         2'b10:   out_nxt = out_cnt + CNT_ONE;
         2'b01:   out_nxt = out_cnt - CNT_ONE;
         default: out_nxt = out_cnt;
      endcase

      ib_cnt_nxt = ibuf_cnt;
      case ({ib_push, ib_pop})
         2'b10:   ib_cnt_nxt = ibuf_cnt + CNT_ONE;
         2'b01:   ib_cnt_nxt = ibuf_cnt - CNT_ONE;
         default: ib_cnt_nxt = ibuf_cnt;
      endcase
   end

   assign fs_to_ds_pc   = ibuf_mem[ib_rd].pc;
   assign fs_to_ds_inst = ibuf_mem[ib_rd].inst;

   always_ff @(posedge clk) begin
      if (accept) tag_mem[tag_wr] <= pc;
      if (ib_push) ibuf_mem[ib_wr] <= ib_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         out_cnt     <= '0;
         discard_cnt <= '0;
         ibuf_cnt    <= '0;
         tag_wr      <= '0;
         tag_rd      <= '0;
         ib_wr       <= '0;
         ib_rd       <= '0;
      end else begin
         out_cnt <= out_nxt;
         if (accept) tag_wr <= tag_wr + PTR_ONE;
         if (resp)   tag_rd <= tag_rd + PTR_ONE;
         if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc          <= redirect_pc;
            discard_cnt <= out_nxt;
            ibuf_cnt    <= '0;
            ib_wr       <= '0;
            ib_rd       <= '0;
         end else begin
            if (accept) pc <= pc + 32'd4;
            if (resp && (discard_cnt != '0)) discard_cnt <= discard_cnt - CNT_ONE;
            ibuf_cnt <= ib_cnt_nxt;
            if (ib_push) ib_wr <= ib_wr + PTR_ONE;
            if (ib_pop)  ib_rd <= ib_rd + PTR_ONE;
         end
      end
   end

`ifdef FETCH_ADEF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         adef_done <= 1'b0;
      end else if (redirect) begin
         adef_done <= 1'b0;
      end else if (adef_push) begin
         adef_done <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (ib_push) ib_excp[ib_wr] <= adef_push;
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus a queue of expected deliveries.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        br_valid, flush_valid;
   logic [31:0] br_target, flush_target;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        ds_allowin;
   logic        fs_to_ds_valid;
   logic [31:0] fs_to_ds_pc, fs_to_ds_inst;
   logic        fs_to_ds_excp;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        excp;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem_q[$];
   exp_t        mon_e;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int dlv_cnt = 0;
   int first_dlv = -1;
   int last_dlv = -1;
   int rel_cyc = 0;
   bit mem_resp_en = 0;

   fetch_unit dut (
      .clk(clk), .reset(reset),
      .br_valid(br_valid), .br_target(br_target),
      .flush_valid(flush_valid), .flush_target(flush_target),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .ds_allowin(ds_allowin), .fs_to_ds_valid(fs_to_ds_valid),
      .fs_to_ds_pc(fs_to_ds_pc), .fs_to_ds_inst(fs_to_ds_inst), .fs_to_ds_excp(fs_to_ds_excp)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5a5a0ff0;
   endfunction

   function automatic void push_seq(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         logic [31:0] a;
         a = base + 32'(4 * i);
         exp_q.push_back('{pc: a, inst: inst_of(a), excp: 1'b0});
      end
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory: returns each accepted address one cycle later, in order, when enabled.
   initial begin
      inst_data_ok = 1'b0;
      inst_rdata   = '0;
      forever begin
         @(posedge clk);
         #2;
         if (reset) begin
            mem_q.delete();
            inst_data_ok = 1'b0;
            inst_rdata   = '0;
         end else if (mem_resp_en && mem_q.size() > 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = inst_of(mem_q.pop_front());
         end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = '0;
         end
      end
   end

   // Monitor: records accepted requests, checks each delivery against the queue head.
   initial forever begin
      @(negedge clk);
      if (inst_req === 1'b1 && inst_addr_ok === 1'b1) begin
         mem_q.push_back(inst_addr);
         acc_cnt++;
      end
      if (fs_to_ds_valid === 1'b1 && ds_allowin === 1'b1) begin
         dlv_cnt++;
         if (first_dlv < 0) first_dlv = cyc;
         last_dlv = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL deliver_unexpected: got pc=%h inst=%h, required no delivery", fs_to_ds_pc, fs_to_ds_inst);
         end else begin
            mon_e = exp_q.pop_front();
            if (fs_to_ds_pc !== mon_e.pc || fs_to_ds_inst !== mon_e.inst || fs_to_ds_excp !== mon_e.excp) begin
               errors++;
               $display("FAIL deliver: got pc=%h inst=%h excp=%b, required pc=%h inst=%h excp=%b",
                        fs_to_ds_pc, fs_to_ds_inst, fs_to_ds_excp, mon_e.pc, mon_e.inst, mon_e.excp);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      br_valid = 1'b0;
      flush_valid = 1'b0;
      inst_addr_ok = 1'b0;
      ds_allowin = 1'b0;
      mem_resp_en = 1'b0;
      exp_q.delete();
      step(2);
      reset = 1'b0;
      acc_cnt = 0;
      dlv_cnt = 0;
      first_dlv = -1;
      last_dlv = -1;
      rel_cyc = cyc;
   endtask

   task automatic drain(input int budget, output int left);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step(1);
         n++;
      end
      left = exp_q.size();
      exp_q.delete();
      ds_allowin = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      br_valid = 1'b0; br_target = '0;
      flush_valid = 1'b0; flush_target = '0;
      inst_addr_ok = 1'b1;
      ds_allowin = 1'b1;
      step(1);
      @(negedge clk);
      checks++;
      if (inst_req !== 1'b0) begin errors++; $display("FAIL reset_inst_req: got %b, required 0", inst_req); end
      checks++;
      if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", fs_to_ds_valid); end
      @(posedge clk); #1;
      reset = 1'b0;
      inst_addr_ok = 1'b0;
      @(negedge clk);
      checks++;
      if (inst_req !== 1'b1) begin errors++; $display("FAIL release_inst_req: got %b, required 1", inst_req); end
      checks++;
      if (inst_addr !== 32'h1c000000) begin errors++; $display("FAIL release_addr: got %h, required 1c000000", inst_addr); end
      checks++;
      if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b, required 0", fs_to_ds_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_stream();
      int left;
      do_reset();
      inst_addr_ok = 1'b1; mem_resp_en = 1'b1; ds_allowin = 1'b1;
      push_seq(32'h1c000000, 16);
      drain(60, left);
      checks++;
      if (left != 0) begin errors++; $display("FAIL stream_drain: %0d left, required 0", left); end
      checks++;
      if (first_dlv - rel_cyc != 2) begin errors++; $display("FAIL stream_latency: got %0d cycles, required 2", first_dlv - rel_cyc); end
      checks++;
      if (last_dlv - first_dlv != 15) begin errors++; $display("FAIL stream_rate: got %0d cycles for 16, required 15", last_dlv - first_dlv); end
   endtask

   task automatic test_backpressure();
      int left;
      do_reset();
      inst_addr_ok = 1'b1; mem_resp_en = 1'b1; ds_allowin = 1'b0;
      step(10);
      @(negedge clk);
      checks++;
      if (inst_req !== 1'b0) begin errors++; $display("FAIL bp_inst_req: got %b, required 0", inst_req); end
      checks++;
      if (acc_cnt != 4) begin errors++; $display("FAIL bp_accepted: got %0d, required 4", acc_cnt); end
      checks++;
      if (fs_to_ds_valid !== 1'b1 || fs_to_ds_pc !== 32'h1c000000) begin
         errors++; $display("FAIL bp_head: got valid=%b pc=%h, required valid=1 pc=1c000000", fs_to_ds_valid, fs_to_ds_pc);
      end
      @(posedge clk); #1;
      push_seq(32'h1c000000, 8);
      ds_allowin = 1'b1;
      drain(40, left);
      checks++;
      if (left != 0) begin errors++; $display("FAIL bp_drain: %0d left, required 0", left); end
   endtask

   task automatic test_branch();
      int left;
      do_reset();
      inst_addr_ok = 1'b1; ds_allowin = 1'b1;
      step(4);
      @(negedge clk);
      checks++;
      if (acc_cnt != 2 || inst_req !== 1'b0) begin
         errors++; $display("FAIL br_outstanding: got accepted=%0d req=%b, required 2 and 0", acc_cnt, inst_req);
      end
      @(posedge clk); #1;
      br_valid = 1'b1; br_target = 32'h1c000100;
      push_seq(32'h1c000100, 4);
      step(1);
      br_valid = 1'b0; mem_resp_en = 1'b1;
      drain(40, left);
      checks++;
      if (left != 0) begin errors++; $display("FAIL br_drain: %0d left, required 0", left); end
   endtask

   task automatic test_flush_priority();
      int left;
      do_reset();
      inst_addr_ok = 1'b1; ds_allowin = 1'b1;
      step(4);
      flush_valid = 1'b1; flush_target = 32'h1c008000;
      br_valid = 1'b1; br_target = 32'h1c000200;
      push_seq(32'h1c008000, 4);
      step(1);
      flush_valid = 1'b0; br_valid = 1'b0; mem_resp_en = 1'b1;
      drain(40, left);
      checks++;
      if (left != 0) begin errors++; $display("FAIL flush_drain: %0d left, required 0", left); end
   endtask

   task automatic test_redirect_data_ok();
      int left;
      do_reset();
      inst_addr_ok = 1'b1; ds_allowin = 1'b1;
      step(4);
      // First old response arrives in the redirect cycle itself.
      br_valid = 1'b1; br_target = 32'h1c000300; mem_resp_en = 1'b1;
      push_seq(32'h1c000300, 4);
      step(1);
      br_valid = 1'b0;
      drain(40, left);
      checks++;
      if (left != 0) begin errors++; $display("FAIL rdo_drain: %0d left, required 0", left); end
   endtask

   task automatic test_redirect_stream();
      int left;
      do_reset();
      inst_addr_ok = 1'b1; mem_resp_en = 1'b1; ds_allowin = 1'b0;
      step(2);
      br_valid = 1'b1; br_target = 32'h1c000500;
      @(negedge clk);
      checks++;
      if (inst_req !== 1'b0) begin errors++; $display("FAIL rs_inst_req: got %b, required 0", inst_req); end
      checks++;
      if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL rs_valid: got %b, required 0", fs_to_ds_valid); end
      @(posedge clk); #1;
      br_valid = 1'b0; ds_allowin = 1'b1;
      push_seq(32'h1c000500, 4);
      drain(40, left);
      checks++;
      if (left != 0) begin errors++; $display("FAIL rs_drain: %0d left, required 0", left); end
   endtask

   task automatic test_reset_mid();
      int left;
      do_reset();
      inst_addr_ok = 1'b1; mem_resp_en = 1'b1; ds_allowin = 1'b0;
      br_valid = 1'b1; br_target = 32'h1c000400;
      step(1);
      br_valid = 1'b0;
      step(6);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (fs_to_ds_valid !== 1'b0 || inst_req !== 1'b0) begin
         errors++; $display("FAIL mid_reset_outputs: got valid=%b req=%b, required 0 and 0", fs_to_ds_valid, inst_req);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      ds_allowin = 1'b1;
      push_seq(32'h1c000000, 4);
      drain(40, left);
      checks++;
      if (left != 0) begin errors++; $display("FAIL mid_reset_drain: %0d left, required 0", left); end
   endtask

`ifdef FETCH_ADEF_EN
   task automatic test_adef();
      int left;
      do_reset();
      br_valid = 1'b1; br_target = 32'h1c000102;
      step(1);
      br_valid = 1'b0; inst_addr_ok = 1'b1;
      step(3);
      @(negedge clk);
      checks++;
      if (inst_req !== 1'b0 || acc_cnt != 0) begin
         errors++; $display("FAIL adef_no_req: got req=%b accepted=%0d, required 0 and 0", inst_req, acc_cnt);
      end
      checks++;
      if (fs_to_ds_valid !== 1'b1) begin errors++; $display("FAIL adef_valid: got %b, required 1", fs_to_ds_valid); end
      @(posedge clk); #1;
      exp_q.push_back('{pc: 32'h1c000102, inst: 32'h0, excp: 1'b1});
      ds_allowin = 1'b1;
      drain(20, left);
      checks++;
      if (left != 0) begin errors++; $display("FAIL adef_drain: %0d left, required 0", left); end
      ds_allowin = 1'b1;
      step(5);
      @(negedge clk);
      checks++;
      if (dlv_cnt != 1 || fs_to_ds_valid !== 1'b0) begin
         errors++; $display("FAIL adef_stall: got deliveries=%0d valid=%b, required 1 and 0", dlv_cnt, fs_to_ds_valid);
      end
      @(posedge clk); #1;
      ds_allowin = 1'b0;
   endtask
`else
   task automatic test_unaligned();
      int left;
      do_reset();
      br_valid = 1'b1; br_target = 32'h1c000102;
      step(1);
      br_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (inst_req !== 1'b1 || inst_addr !== 32'h1c000100) begin
         errors++; $display("FAIL unaligned_addr: got req=%b addr=%h, required 1 and 1c000100", inst_req, inst_addr);
      end
      @(posedge clk); #1;
      exp_q.push_back('{pc: 32'h1c000102, inst: inst_of(32'h1c000100), excp: 1'b0});
      inst_addr_ok = 1'b1; mem_resp_en = 1'b1; ds_allowin = 1'b1;
      drain(20, left);
      checks++;
      if (left != 0) begin errors++; $display("FAIL unaligned_drain: %0d left, required 0", left); end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_branch();
      test_flush_priority();
      test_redirect_data_ok();
      test_redirect_stream();
      test_reset_mid();
`ifdef FETCH_ADEF_EN
      test_adef();
`else
      test_unaligned();
`endif
      step(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
